eth_rx_framer: RTL

- Consumes the byte stream RX_DATA/RX_DV produced by the rgmii block; runs in the RGMII_RX_CLK domain.
- Strips the preamble and SFD, checks length and the CRC-32 FCS, and strips the FCS.
- Emits payload bytes (DA through end of data) as a valid/last/error beat stream to the MAC RX logic.
- Has no backpressure; the consumer must accept one beat per cycle.

---
 rtl/eth_pkg.sv | 20 ++
 rtl/eth_crc32_d8.sv | 17 +
 rtl/eth_rx_framer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants and state encoding for the Ethernet RX path
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    PAY,
    END,
    DROP
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam logic [47:0] BCAST_ADDR    = 48'hFFFF_FFFF_FFFF;
  localparam int          LEN_W         = 11;

endpackage

// File: rtl/eth_crc32_d8.sv
// rtl/eth_crc32_d8.sv - combinational reflected CRC-32 update for one byte
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/eth_rx_framer.sv
// rtl/eth_rx_framer.sv - strips preamble/SFD and FCS, checks length and CRC, emits payload beats
// ETH_RX_MAC_FILTER_EN adds a destination address filter evaluated at the sixth byte.
module eth_rx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
`ifdef ETH_RX_MAC_FILTER_EN
  ,
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] RX_DATA,
  input  logic       RX_DV,
  output logic [7:0] M_DATA,
  output logic       M_VALID,
  output logic       M_LAST,
  output logic       M_ERR,
  output logic       FRAME_OK,
  output logic       FRAME_BAD
);

  localparam logic [LEN_W-1:0] MIN_L     = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] PEND_FILL = LEN_W'(5);

  state_t           state;
  state_t           start_state;
  logic             dv_q;
  logic [3:0][7:0]  dly;
  logic [7:0]       pend;
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [LEN_W-1:0] len;
  logic             rise;
  logic             pend_vld;
  logic             err;
  logic             reject;

  eth_crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (RX_DATA),
    .crc_out (crc_next)
  );

  assign rise     = RX_DV & ~dv_q;
  // Pending holds a payload byte once the four FCS candidates sit in front of it.
  assign pend_vld = (len >= PEND_FILL);
  assign err      = (crc != CRC32_RESIDUE) || (len < MIN_L) || (len > MAX_L);

`ifdef ETH_RX_MAC_FILTER_EN
  logic [47:0] da;
  assign da     = {pend, dly[3], dly[2], dly[1], dly[0], RX_DATA};
  assign reject = (len == PEND_FILL) && !((da == MAC_ADDR) || (da == BCAST_ADDR) || pend[0]);
`else
  assign reject = 1'b0;
`endif

  // Shared by IDLE and END so a frame may start in the cycle that closes the previous one.
  always_comb begin
    start_state = IDLE;
    if (rise) begin
      if (RX_DATA == PREAMBLE_BYTE)  start_state = PRE;
      else if (RX_DATA == SFD_BYTE)  start_state = PAY;
      else                           start_state = DROP;
    end else if (RX_DV) begin
      start_state = DROP;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      dv_q      <= 1'b1;  // a frame already in flight at release must not look like a rise
      dly       <= '0;
      pend      <= '0;
      crc       <= CRC32_INIT;
      len       <= '0;
      M_DATA    <= '0;
      M_VALID   <= 1'b0;
      M_LAST    <= 1'b0;
      M_ERR     <= 1'b0;
      FRAME_OK  <= 1'b0;
      FRAME_BAD <= 1'b0;
    end else begin
      dv_q      <= RX_DV;
      M_VALID   <= 1'b0;
      M_LAST    <= 1'b0;
      M_ERR     <= 1'b0;
      FRAME_OK  <= 1'b0;
      FRAME_BAD <= 1'b0;
      if (state != PAY) begin
        crc <= CRC32_INIT;
        len <= '0;
      end
      case (state)
        IDLE: state <= start_state;
        PRE: begin
          if (!RX_DV)                         state <= IDLE;
          else if (RX_DATA == SFD_BYTE)       state <= PAY;
          else if (RX_DATA != PREAMBLE_BYTE)  state <= DROP;
        end
        PAY: begin
          if (!RX_DV) begin
            state <= END;
          end else if (reject) begin
            state <= DROP;
          end else begin
            crc  <= crc_next;
            len  <= (len == '1) ? len : len + 1'b1;
            dly  <= {dly[2:0], RX_DATA};
            pend <= dly[3];
            if (pend_vld) begin
              M_VALID <= 1'b1;
              M_DATA  <= pend;
            end
          end
        end
        END: begin
          if (pend_vld) begin
            M_VALID   <= 1'b1;
            M_DATA    <= pend;
            M_LAST    <= 1'b1;
            M_ERR     <= err;
            FRAME_OK  <= ~err;
            FRAME_BAD <= err;
          end else begin
            FRAME_BAD <= 1'b1;
          end
          state <= start_state;
        end
        DROP: if (!RX_DV) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
